wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Consumer end of the memory-stage result interface (wd/wreg/wdata). Captures memory-stage
//  results in a MEM/WB pipeline register, commits them to the 32x32 general register file,
//  and serves two combinational read ports to decode with write-to-read bypass.
//  Sits between the memory stage and the decode stage.
// PARAMETERS
//  DATA_W  32  register/data width (`RegBus)
//  ADDR_W  5   register address width (`RegAddrBus)
//  NREGS   32  number of architectural registers; register 0 is hardwired to zero
// PORTS
//  clk         in   1       single clock; all state updates on rising edge
//  rst         in   1       synchronous, active-high reset (`RstEnable = 1'b1)
//  stall_i     in   1       1 = hold MEM/WB register contents
//  flush_i     in   1       1 = load a bubble into MEM/WB register
//  mem_wd      in   ADDR_W  destination register from memory stage
//  mem_wreg    in   1       write enable from memory stage
//  mem_wdata   in   DATA_W  result data from memory stage
//  re1/re2     in   1       read-port enables
//  raddr1/2    in   ADDR_W  read addresses
//  rdata1/2    out  DATA_W  read data (combinational)
//  wb_wd_o     out  ADDR_W  MEM/WB register: destination
//  wb_wreg_o   out  1       MEM/WB register: write enable
//  wb_wdata_o  out  DATA_W  MEM/WB register: data
// BEHAVIOUR
//  - MEM/WB register priority per edge: rst > flush_i > stall_i > load.
//    rst or flush_i: wd=`NOPRegAddr(0), wreg=`WriteDisable(0), wdata=`ZeroWord. stall_i: hold.
//    Otherwise load mem_wd/mem_wreg/mem_wdata. Latency: 1 cycle to the wb_* outputs.
//  - Register file write: on an edge with rst=0, wb_wreg_o=1 and wb_wd_o!=0,
//    regs[wb_wd_o] <= wb_wdata_o. Commit point = 2nd edge after the memory stage presents data.
//  - Writes to register 0 are discarded; regs[0] always reads 0.
//  - rst clears all NREGS registers to 0 on the same edge; a pending MEM/WB write is dropped.
//  - During a stall with wb_wreg_o=1 the same write recommits every cycle (idempotent, legal).
//  - Read port n (combinational), first match wins:
//      rst=1 -> 0; re_n=0 -> 0; raddr_n=0 -> 0;
//      wb_wreg_o=1 && wb_wd_o==raddr_n -> wb_wdata_o (bypass);
//      else regs[raddr_n].
//  - Both ports may read the same address, including the bypassed address, in the same cycle.
//  - flush_i and stall_i together: flush wins and a bubble is loaded.
//  - No X propagation: every output is driven on every path.
// STRUCTURE
//  - Shared defines file holds RstEnable, WriteEnable/WriteDisable, ReadEnable, ZeroWord,
//    NOPRegAddr, RegBus, RegAddrBus, RegNum. No local literals for these values.
//  - Sub-module mem_wb: the MEM/WB pipeline register (stall/flush/reset logic).
//  - Top level wb_regfile: instantiates mem_wb, plus the register array, write logic and the
//    two read muxes with bypass.
// TESTING
//  1. Reset: rst=1 for 1 edge -> wb_* = 0, rdata1/2 = 0; after reset, reading r1..r31 -> 0.
//  2. Write path: mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF for 1 cycle -> next cycle
//     wb_wd_o=5; re1=1, raddr1=5 returns 0xDEADBEEF via bypass; cycle after returns it from the
//     array, with mem_wreg=0.
//  3. R0 guard: write 0x12345678 to reg 0 -> raddr1=0 reads 0 both in the bypass cycle and after.
//  4. Stall/flush: load reg 7=0xA5 with stall_i=1 on the next edge -> wb_* hold 7/1/0xA5.
//     Assert flush_i and stall_i together -> wb_wreg_o=0 and wb_wd_o=0; reg 7 retains 0xA5.
//  5. Reset mid-operation: wb_wreg_o=1 for reg 9=0x55 with rst=1 on that edge -> reg 9 reads 0
//     and wb_* = 0.
//  6. Dual port/enables: regs 3=0x3, 4=0x4; raddr1=3, raddr2=4 -> 0x3/0x4; re2=0 -> rdata2=0;
//     with both ports at the bypassed address, both ports return the bypass data.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// Encodings for reset, enables and the NOP destination live here only.
package wb_regfile_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

endpackage

// File: rtl/wb_regfile_mem_wb.sv
// MEM/WB pipeline register: reset and flush load a bubble, stall holds.
// Priority on each edge is reset, then flush, then stall, then load.
module wb_regfile_mem_wb
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata
);

    localparam logic [DATA_W-1:0] ZERO_D = DATA_W'(ZERO_WORD);
    localparam logic [ADDR_W-1:0] NOP_A  = ADDR_W'(NOP_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush) begin
            wb_wd    <= NOP_A;
            wb_wreg  <= WRITE_DISABLE;
            wb_wdata <= ZERO_D;
        end else if (!stall) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB register, register file with hardwired r0,
// and two combinational read ports that bypass the pending write.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREGS  = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o
);

    localparam logic [DATA_W-1:0] ZERO_D = DATA_W'(ZERO_WORD);
    localparam logic [ADDR_W-1:0] NOP_A  = ADDR_W'(NOP_REG_ADDR);

    logic [DATA_W-1:0] regs [NREGS];

    wb_regfile_mem_wb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall_i),
        .flush     (flush_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .wb_wd     (wb_wd_o),
        .wb_wreg   (wb_wreg_o),
        .wb_wdata  (wb_wdata_o)
    );

    // Reset drops any pending commit; writes to r0 are discarded so it stays zero.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            regs <= '{default: ZERO_D};
        end else if (wb_wreg_o == WRITE_ENABLE && wb_wd_o != NOP_A) begin
            regs[wb_wd_o] <= wb_wdata_o;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_v,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              wreg,
        input logic [ADDR_W-1:0] wd,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] arr
    );
        logic [DATA_W-1:0] res;
        res = ZERO_D;
        if (rst_v == RST_ENABLE)                  res = ZERO_D;
        else if (re != READ_ENABLE)               res = ZERO_D;
        else if (raddr == NOP_A)                  res = ZERO_D;
        else if (wreg == WRITE_ENABLE && wd == raddr) res = wdata;
        else                                      res = arr;
        return res;
    endfunction

    always_comb begin
        rdata1 = read_port(rst, re1, raddr1, wb_wreg_o, wb_wd_o, wb_wdata_o, regs[raddr1]);
        rdata2 = read_port(rst, re2, raddr2, wb_wreg_o, wb_wd_o, wb_wdata_o, regs[raddr2]);
    end

endmodule
